// File: rtl/keypad_matrix_scan_pkg.sv
// Shared scanner definitions: FSM states, active-low column strobes and small decode helpers.
// The column patterns are the same ones the seven-segment display scanner drives.
package keypad_matrix_scan_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } scan_state_t;

  localparam logic [3:0] COL0 = 4'b1110;
  localparam logic [3:0] COL1 = 4'b1101;
  localparam logic [3:0] COL2 = 4'b1011;
  localparam logic [3:0] COL3 = 4'b0111;

  function automatic logic [3:0] col_decode(input logic [1:0] idx);
    logic [3:0] pat;
    unique case (idx)
      2'd0:    pat = COL0;
      2'd1:    pat = COL1;
      2'd2:    pat = COL2;
      default: pat = COL3;
    endcase
    return pat;
  endfunction

  // Row 0 has the highest priority when several rows read low.
  function automatic logic [1:0] lowest_low_row(input logic [3:0] rows);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!rows[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_matrix_scan_sync_2ff.sv
// Two-flop synchronizer for the asynchronous matrix rows; resets to all-ones (no key).
// Latency two base_scan_clock edges; no flow control.
module sync_2ff #(
  parameter int         WIDTH   = 4,
  parameter logic [3:0] RST_VAL = 4'b1111
) (
  input  logic             base_scan_clock,
  input  logic             RESET,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge base_scan_clock or posedge RESET) begin
    if (RESET) begin
      meta <= WIDTH'(RST_VAL);
      q    <= WIDTH'(RST_VAL);
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_matrix_scan.sv
// 4x4 active-low keypad scanner: column strobe, row sync, debounce, one key code per press.
// key_valid follows the detecting sample edge by DEBOUNCE_CYCLES+1 edges; no backpressure.
module keypad_matrix_scan
  import keypad_matrix_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES   = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       base_scan_clock,
  input  logic       RESET,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam int DW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int BW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SETTLE_CYCLES - 1);
  localparam logic [BW-1:0] DB_LAST    = BW'(DEBOUNCE_CYCLES - 1);

  scan_state_t   state, state_nxt;
  logic [3:0]    rs;
  logic [1:0]    col_idx;
  logic [1:0]    row_idx;
  logic [DW-1:0] dwell;
  logic [BW-1:0] db;

  logic dwell_done, db_done, row_low, any_low;
  logic col_adv, dwell_inc, dwell_clr, latch_row, db_inc, db_clr, accept, release_key;

  sync_2ff #(.WIDTH(4), .RST_VAL(4'b1111)) u_row_sync (
    .base_scan_clock (base_scan_clock),
    .RESET           (RESET),
    .d               (row_in),
    .q               (rs)
  );

  assign dwell_done = (dwell == DWELL_LAST);
  assign db_done    = (db == DB_LAST);
  assign row_low    = ~rs[row_idx];
  assign any_low    = (rs != 4'b1111);
  assign col_out    = col_decode(col_idx);

  always_ff @(posedge base_scan_clock or posedge RESET) begin
    if (RESET) state <= SCAN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      SCAN:     if (dwell_done && any_low) state_nxt = DEBOUNCE;
      DEBOUNCE: if (!row_low) state_nxt = SCAN;
                else if (db_done) state_nxt = HELD;
      HELD:     if (!row_low && db_done) state_nxt = SCAN;
      default:  state_nxt = SCAN;
    endcase
  end

  // Control strobes; the column index only moves when leaving a column for good.
  always_comb begin
    col_adv     = 1'b0;
    dwell_inc   = 1'b0;
    dwell_clr   = 1'b0;
    latch_row   = 1'b0;
    db_inc      = 1'b0;
    db_clr      = 1'b0;
    accept      = 1'b0;
    release_key = 1'b0;
    unique case (state)
      SCAN: begin
        if (!dwell_done) begin
          dwell_inc = 1'b1;
        end else if (!any_low) begin
          col_adv   = 1'b1;
          dwell_clr = 1'b1;
        end else begin
          latch_row = 1'b1;
          db_clr    = 1'b1;
        end
      end
      DEBOUNCE: begin
        if (!row_low) begin
          col_adv   = 1'b1;
          dwell_clr = 1'b1;
        end else if (db_done) begin
          accept = 1'b1;
          db_clr = 1'b1;
        end else begin
          db_inc = 1'b1;
        end
      end
      HELD: begin
        if (row_low) begin
          db_clr = 1'b1;
        end else if (db_done) begin
          release_key = 1'b1;
          col_adv     = 1'b1;
          dwell_clr   = 1'b1;
        end else begin
          db_inc = 1'b1;
        end
      end
      default: dwell_clr = 1'b1;
    endcase
  end

  always_ff @(posedge base_scan_clock or posedge RESET) begin
    if (RESET) begin
      col_idx   <= 2'd0;
      row_idx   <= 2'd0;
      dwell     <= '0;
      db        <= '0;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
    end else begin
      key_valid <= accept;
      if (col_adv)   col_idx <= col_idx + 2'd1;
      if (latch_row) row_idx <= lowest_low_row(rs);
      if (dwell_clr)      dwell <= '0;
      else if (dwell_inc) dwell <= dwell + DW'(1);
      if (db_clr)      db <= '0;
      else if (db_inc) db <= db + BW'(1);
      if (accept) begin
        key_code <= {row_idx, col_idx};
        key_down <= 1'b1;
      end
      if (release_key) key_down <= 1'b0;
    end
  end

endmodule
